ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; sits directly downstream of the D/E pipeline register and consumes its E-side outputs.
- Contains operand forwarding muxes, ALUsrc and Regdst muxes, the ALU and an optional iterative multiplier, plus the E/M pipeline register.
- StallE asks the hazard unit to freeze F, D and D/E while a multiply is in progress.

Parameters:
- MUL_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4; N = 32/MUL_BITS iteration cycles.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- RegwriteE, MemtoregE, MemwriteE  in  1 each  control from D/E
- ALUcontrolE  in  3  ALU operation
- ALUsrcE  in  1  1 selects signE as SrcB
- RegdstE  in  1  1 selects rdE as destination
- rtE, rdE  in  5 each  register numbers
- signE, ReadData1E, ReadData2E  in  32 each  immediate and register operands
- ForwardAE, ForwardBE  in  2 each  forward select from hazard unit
- ResultW  in  32  writeback-stage result
- WriteRegE  out  5  combinational destination, to hazard unit
- StallE  out  1  multiply busy; hazard unit holds F/D and D/E while high
- RegwriteM, MemtoregM, MemwriteM  out  1 each  registered control
- ALUoutM, WriteDataM  out  32 each  registered result / store data
- WriteRegM  out  5  registered destination

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high on rst. All state updates on posedge clk.
- Reset: all M outputs = 0, FSM = IDLE, count = 0. StallE is forced to 0 while rst is high. Reset mid-multiply abandons the operation.
- Forwarding, separately for A and B:
  - 00: ReadData1E / ReadData2E
  - 10: ALUoutM
  - 01: ResultW
  - 11: treated as 00
- Operand muxes:
  - SrcB = ALUsrcE ? signE : forwarded B.
  - WriteDataM captures forwarded B, never signE.
  - WriteRegE = RegdstE ? rdE : rtE.
- ALU ops: 010 add, 110 sub, 000 and, 001 or, 100 xor, 101 nor, 111 signed slt (result 1 or 0), 011 mul.
  - Add, sub and mul wrap modulo 2^32; overflow is ignored.
  - Mul result is the low 32 bits of the product.
- Non-mul ops: single cycle. E/M register loads ALU result, control, WriteRegE and WriteDataM every cycle.
- Multiply FSM, states IDLE, MUL, DONE:
  - IDLE with ALUcontrolE=011: StallE=1 combinationally; latch post-forwarding SrcA, SrcB and WriteDataM; clear accumulator; count=0; go to MUL. E/M loads a bubble (RegwriteM=MemwriteM=MemtoregM=0; data fields are don't-care).
  - MUL: StallE=1. Shift-add MUL_BITS multiplier bits per cycle; count++. When count=N-1, go to DONE. E/M loads a bubble every cycle.
  - DONE: StallE=0. E/M loads the product, the D/E control inputs, WriteRegE and the latched WriteDataM. Go to IDLE. ALUcontrolE=011 seen in DONE must not restart the multiply.
- Multiply timing:
  - E occupancy is N+2 cycles; StallE is high for N+1 cycles (N=32 gives 33).
  - A mul immediately following a mul starts normally from IDLE on the next cycle.
- Latched operands are required because ALUoutM and ResultW change during bubbles. Forward selects are ignored in MUL and DONE.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: multiplier FSM present as described above.
- Undefined: no FSM is built. ALUcontrolE=011 produces ALUoutM=0 in one cycle, and StallE is tied to 0.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> all M outputs 0, StallE=0.
- ALU ops, no forwarding, ALUsrcE=0:
  - add A=0xFFFFFFFF, B=2 -> ALUoutM=0x00000001 one cycle later.
  - slt A=0xFFFFFFFE, B=1 -> 1.
  - nor 0, 0 -> 0xFFFFFFFF.
- Forwarding: ALUoutM=0x10, ResultW=0x20, ForwardAE=10, ForwardBE=01, add -> 0x30. ForwardBE=11 with ReadData2E=5 -> B=5.
- ALUsrc/Regdst: ALUsrcE=1, signE=0xFFFFFFFC, A=8, ReadData2E=0x55, RegdstE=0, rtE=7, rdE=9 -> ALUoutM=4, WriteDataM=0x55, WriteRegM=7, WriteRegE=7.
- Multiply (EX_MUL_EN defined, MUL_BITS=1): mul 0x00010001 × 0x00010001 -> StallE high for exactly 33 cycles, bubbles in M throughout; then ALUoutM=0x00020001 with RegwriteM=1. Repeat with MUL_BITS=4 -> 9 stall cycles.
- Reset mid-multiply: rst at cycle 10 of a mul -> StallE=0 and RegwriteM=0 next cycle; a subsequent add 3+4 -> 7 normally.

Source files
------------

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding muxes, ALU, optional iterative multiplier and the E/M register.
// Define EX_MUL_EN to build the multi-cycle multiplier; otherwise mul yields 0 in one cycle.
module ex_stage #(
    parameter int MUL_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegwriteE,
    input  logic        MemtoregE,
    input  logic        MemwriteE,
    input  logic [2:0]  ALUcontrolE,
    input  logic        ALUsrcE,
    input  logic        RegdstE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  rdE,
    input  logic [31:0] signE,
    input  logic [31:0] ReadData1E,
    input  logic [31:0] ReadData2E,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    output logic [4:0]  WriteRegE,
    output logic        StallE,
    output logic        RegwriteM,
    output logic        MemtoregM,
    output logic        MemwriteM,
    output logic [31:0] ALUoutM,
    output logic [31:0] WriteDataM,
    output logic [4:0]  WriteRegM
);
    localparam logic [2:0] OP_MUL = 3'b011;

    if (!(MUL_BITS == 1 || MUL_BITS == 2 || MUL_BITS == 4)) begin : gBadMulBits
        $error("ex_stage: MUL_BITS must be 1, 2 or 4");
    end

    function automatic logic [31:0] aluOp(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        case (op)
            3'b010:  r = a + b;
            3'b110:  r = a - b;
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = ~(a | b);
            3'b111:  r = {31'd0, (sa < sb)};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic [31:0] srcA, fwdB, srcB, aluRes;

    // Code 11 falls back to the register file value like 00.
    always_comb begin
        case (ForwardAE)
            2'b10:   srcA = ALUoutM;
            2'b01:   srcA = ResultW;
            default: srcA = ReadData1E;
        endcase
        case (ForwardBE)
            2'b10:   fwdB = ALUoutM;
            2'b01:   fwdB = ResultW;
            default: fwdB = ReadData2E;
        endcase
    end

    assign srcB      = ALUsrcE ? signE : fwdB;
    assign WriteRegE = RegdstE ? rdE : rtE;
    assign aluRes    = aluOp(ALUcontrolE, srcA, srcB);

`ifdef EX_MUL_EN
    localparam int N = 32 / MUL_BITS;

    typedef enum logic [1:0] {IDLE, MUL, DONE} mulState_t;

    mulState_t   mulState;
    logic [5:0]  mulCount;
    logic [31:0] mulAcc, mulCand, mulPlier, mulWd;

    // Adds mcand shifted by each set bit of the current multiplier digit.
    function automatic logic [31:0] mulStep(input logic [31:0] acc, input logic [31:0] mcand,
                                            input logic [MUL_BITS-1:0] digit);
        logic [31:0] s;
        s = acc;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (digit[i]) s = s + (mcand << i);
        end
        return s;
    endfunction

    assign StallE = !rst && ((mulState == IDLE && ALUcontrolE == OP_MUL) || mulState == MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            mulState   <= IDLE;
            mulCount   <= '0;
            mulAcc     <= '0;
            mulCand    <= '0;
            mulPlier   <= '0;
            mulWd      <= '0;
            RegwriteM  <= 1'b0;
            MemtoregM  <= 1'b0;
            MemwriteM  <= 1'b0;
            ALUoutM    <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
        end else begin
            case (mulState)
                IDLE: begin
                    if (ALUcontrolE == OP_MUL) begin
                        // Operands are latched now; forwarded sources move during the bubbles.
                        mulCand   <= srcA;
                        mulPlier  <= srcB;
                        mulWd     <= fwdB;
                        mulAcc    <= '0;
                        mulCount  <= '0;
                        RegwriteM <= 1'b0;
                        MemtoregM <= 1'b0;
                        MemwriteM <= 1'b0;
                        mulState  <= MUL;
                    end else begin
                        RegwriteM  <= RegwriteE;
                        MemtoregM  <= MemtoregE;
                        MemwriteM  <= MemwriteE;
                        ALUoutM    <= aluRes;
                        WriteDataM <= fwdB;
                        WriteRegM  <= WriteRegE;
                    end
                end
                MUL: begin
                    mulAcc    <= mulStep(mulAcc, mulCand, mulPlier[MUL_BITS-1:0]);
                    mulCand   <= mulCand << MUL_BITS;
                    mulPlier  <= mulPlier >> MUL_BITS;
                    mulCount  <= mulCount + 6'd1;
                    RegwriteM <= 1'b0;
                    MemtoregM <= 1'b0;
                    MemwriteM <= 1'b0;
                    if (mulCount == 6'(N - 1)) mulState <= DONE;
                end
                default: begin
                    RegwriteM  <= RegwriteE;
                    MemtoregM  <= MemtoregE;
                    MemwriteM  <= MemwriteE;
                    ALUoutM    <= mulAcc;
                    WriteDataM <= mulWd;
                    WriteRegM  <= WriteRegE;
                    mulState   <= IDLE;
                end
            endcase
        end
    end
`else
    assign StallE = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            RegwriteM  <= 1'b0;
            MemtoregM  <= 1'b0;
            MemwriteM  <= 1'b0;
            ALUoutM    <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
        end else begin
            RegwriteM  <= RegwriteE;
            MemtoregM  <= MemtoregE;
            MemwriteM  <= MemwriteE;
            ALUoutM    <= aluRes;
            WriteDataM <= fwdB;
            WriteRegM  <= WriteRegE;
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table-driven ALU/forwarding vectors plus multiply and reset sequences.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        RegwriteE, MemtoregE, MemwriteE;
    logic [2:0]  ALUcontrolE;
    logic        ALUsrcE, RegdstE;
    logic [4:0]  rtE, rdE;
    logic [31:0] signE, ReadData1E, ReadData2E, ResultW;
    logic [1:0]  ForwardAE, ForwardBE;

    logic [4:0]  WriteRegE, WriteRegM, WriteRegE4, WriteRegM4;
    logic        StallE, RegwriteM, MemtoregM, MemwriteM;
    logic        StallE4, RegwriteM4, MemtoregM4, MemwriteM4;
    logic [31:0] ALUoutM, WriteDataM, ALUoutM4, WriteDataM4;

    int nAssert = 0;
    int nFail = 0;
    int sel = 0;

    always #5 clk = ~clk;

    ex_stage #(.MUL_BITS(1)) dut (
        .clk(clk), .rst(rst), .RegwriteE(RegwriteE), .MemtoregE(MemtoregE),
        .MemwriteE(MemwriteE), .ALUcontrolE(ALUcontrolE), .ALUsrcE(ALUsrcE),
        .RegdstE(RegdstE), .rtE(rtE), .rdE(rdE), .signE(signE),
        .ReadData1E(ReadData1E), .ReadData2E(ReadData2E), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ResultW(ResultW), .WriteRegE(WriteRegE),
        .StallE(StallE), .RegwriteM(RegwriteM), .MemtoregM(MemtoregM),
        .MemwriteM(MemwriteM), .ALUoutM(ALUoutM), .WriteDataM(WriteDataM),
        .WriteRegM(WriteRegM));

    ex_stage #(.MUL_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .RegwriteE(RegwriteE), .MemtoregE(MemtoregE),
        .MemwriteE(MemwriteE), .ALUcontrolE(ALUcontrolE), .ALUsrcE(ALUsrcE),
        .RegdstE(RegdstE), .rtE(rtE), .rdE(rdE), .signE(signE),
        .ReadData1E(ReadData1E), .ReadData2E(ReadData2E), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ResultW(ResultW), .WriteRegE(WriteRegE4),
        .StallE(StallE4), .RegwriteM(RegwriteM4), .MemtoregM(MemtoregM4),
        .MemwriteM(MemwriteM4), .ALUoutM(ALUoutM4), .WriteDataM(WriteDataM4),
        .WriteRegM(WriteRegM4));

    wire        sStall = (sel != 0) ? StallE4 : StallE;
    wire [2:0]  sCtrl  = (sel != 0) ? {RegwriteM4, MemtoregM4, MemwriteM4}
                                    : {RegwriteM, MemtoregM, MemwriteM};
    wire [31:0] sAlu   = (sel != 0) ? ALUoutM4 : ALUoutM;
    wire [31:0] sWd    = (sel != 0) ? WriteDataM4 : WriteDataM;
    wire [4:0]  sWr    = (sel != 0) ? WriteRegM4 : WriteRegM;

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] rd1, rd2, sgn, resW;
        logic [1:0]  fa, fb;
        logic        aluSrc, regDst;
        logic [4:0]  rt, rd;
        logic [2:0]  ctrl;
        logic [31:0] expAlu, expWd;
        logic [4:0]  expWr;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [2:0] ctl, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] sgn,
                                input logic [31:0] resW, input logic [1:0] fa,
                                input logic [1:0] fb, input logic aluSrc, input logic regDst,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [2:0] ctrl, input logic [31:0] expAlu,
                                input logic [31:0] expWd, input logic [4:0] expWr);
        vec_t v;
        v.ctl = ctl; v.rd1 = rd1; v.rd2 = rd2; v.sgn = sgn; v.resW = resW;
        v.fa = fa; v.fb = fb; v.aluSrc = aluSrc; v.regDst = regDst;
        v.rt = rt; v.rd = rd; v.ctrl = ctrl;
        v.expAlu = expAlu; v.expWd = expWd; v.expWr = expWr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ALUcontrolE = v.ctl;
        ReadData1E  = v.rd1;
        ReadData2E  = v.rd2;
        signE       = v.sgn;
        ResultW     = v.resW;
        ForwardAE   = v.fa;
        ForwardBE   = v.fb;
        ALUsrcE     = v.aluSrc;
        RegdstE     = v.regDst;
        rtE         = v.rt;
        rdE         = v.rd;
        {RegwriteE, MemtoregE, MemwriteE} = v.ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addSeven(input string tag);
        drive(mk(3'b010, 32'd3, 32'd4, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1,
                 5'd1, 5'd11, 3'b100, 32'd7, 32'd4, 5'd11));
        #1;
        check({tag, " StallE"}, 32'(sStall), 32'd0);
        tick();
        check({tag, " ALUoutM"}, sAlu, 32'd7);
        check({tag, " ctrlM"}, 32'(sCtrl), 32'd4);
    endtask

`ifdef EX_MUL_EN
    task automatic mulRun(input int which, input int expStall);
        int cnt;
        int bubbleBad;
        string tag;
        tag = (which != 0) ? "mul4" : "mul1";
        sel = which;
        cnt = 0;
        bubbleBad = 0;
        drive(mk(3'b011, 32'h00010001, 32'h00010001, 32'h0000ABCD, 32'd0, 2'b00, 2'b00,
                 1'b0, 1'b1, 5'd2, 5'd12, 3'b100, 32'h00020001, 32'h00010001, 5'd12));
        #1;
        check({tag, " stall start"}, 32'(sStall), 32'd1);
        while (sStall && cnt < 100) begin
            tick();
            cnt++;
            if (cnt == 1) begin
                // Forwarded sources go stale during the bubbles; the latched operands must win.
                ForwardAE = 2'b01;
                ForwardBE = 2'b10;
                ResultW   = 32'hDEAD0000;
            end
            if (sCtrl != 3'b000) bubbleBad++;
        end
        check({tag, " stall cycles"}, 32'(cnt), 32'(expStall));
        check({tag, " bubbles"}, 32'(bubbleBad), 32'd0);
        tick();
        check({tag, " product"}, sAlu, 32'h00020001);
        check({tag, " ctrlM"}, 32'(sCtrl), 32'd4);
        check({tag, " WriteDataM"}, sWd, 32'h00010001);
        check({tag, " WriteRegM"}, 32'(sWr), 32'd12);
        addSeven({tag, " follow add"});
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(3'b010, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1,
                      5'd3, 5'd4, 3'b100, 32'h00000001, 32'd2, 5'd4);
        vecs[1]  = mk(3'b110, 32'd5, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0,
                      5'd5, 5'd6, 3'b100, 32'hFFFFFFFE, 32'd7, 5'd5);
        vecs[2]  = mk(3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0,
                      1'b1, 5'd1, 5'd2, 3'b100, 32'hF000F000, 32'hFF00FF00, 5'd2);
        vecs[3]  = mk(3'b001, 32'h0000000F, 32'h000000F0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0,
                      1'b1, 5'd1, 5'd3, 3'b100, 32'h000000FF, 32'h000000F0, 5'd3);
        vecs[4]  = mk(3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0,
                      1'b1, 5'd1, 5'd8, 3'b100, 32'hF0F00F0F, 32'h0F0F0F0F, 5'd8);
        vecs[5]  = mk(3'b101, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1,
                      5'd1, 5'd10, 3'b100, 32'hFFFFFFFF, 32'd0, 5'd10);
        vecs[6]  = mk(3'b111, 32'hFFFFFFFE, 32'd1, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1,
                      5'd1, 5'd13, 3'b100, 32'd1, 32'd1, 5'd13);
        vecs[7]  = mk(3'b111, 32'd1, 32'hFFFFFFFE, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1,
                      5'd1, 5'd14, 3'b100, 32'd0, 32'hFFFFFFFE, 5'd14);
        vecs[8]  = mk(3'b010, 32'd8, 32'd8, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0,
                      5'd15, 5'd16, 3'b001, 32'h00000010, 32'd8, 5'd15);
        vecs[9]  = mk(3'b010, 32'h111, 32'h222, 32'd0, 32'h20, 2'b10, 2'b01, 1'b0, 1'b1,
                      5'd1, 5'd17, 3'b100, 32'h00000030, 32'h20, 5'd17);
        vecs[10] = mk(3'b001, 32'd0, 32'd5, 32'd0, 32'h20, 2'b11, 2'b11, 1'b0, 1'b1,
                      5'd1, 5'd18, 3'b100, 32'd5, 32'd5, 5'd18);
        vecs[11] = mk(3'b010, 32'd8, 32'h55, 32'hFFFFFFFC, 32'd0, 2'b00, 2'b00, 1'b1, 1'b0,
                      5'd7, 5'd9, 3'b010, 32'd4, 32'h55, 5'd7);

        // Reset with arbitrary inputs, including a mul opcode.
        rst = 1'b1;
        drive(mk(3'b011, 32'h12345678, 32'h9ABCDEF0, 32'h11111111, 32'h22222222, 2'b10,
                 2'b01, 1'b1, 1'b1, 5'd21, 5'd22, 3'b111, 32'd0, 32'd0, 5'd0));
        #1;
        check("reset StallE comb", 32'(StallE), 32'd0);
        tick();
        tick();
        check("reset StallE", 32'(StallE), 32'd0);
        check("reset ctrlM", 32'({RegwriteM, MemtoregM, MemwriteM}), 32'd0);
        check("reset ALUoutM", ALUoutM, 32'd0);
        check("reset WriteDataM", WriteDataM, 32'd0);
        check("reset WriteRegM", 32'(WriteRegM), 32'd0);

        drive(vecs[0]);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d WriteRegE", i), 32'(WriteRegE), 32'(vecs[i].expWr));
            check($sformatf("vec%0d StallE", i), 32'(StallE), 32'd0);
            tick();
            check($sformatf("vec%0d ALUoutM", i), ALUoutM, vecs[i].expAlu);
            check($sformatf("vec%0d WriteDataM", i), WriteDataM, vecs[i].expWd);
            check($sformatf("vec%0d WriteRegM", i), 32'(WriteRegM), 32'(vecs[i].expWr));
            check($sformatf("vec%0d ctrlM", i), 32'({RegwriteM, MemtoregM, MemwriteM}),
                  32'(vecs[i].ctrl));
        end

`ifdef EX_MUL_EN
        mulRun(0, 33);
        rst = 1'b1;
        ALUcontrolE = 3'b010;
        tick();
        rst = 1'b0;
        mulRun(1, 9);

        // Reset in the middle of a multiply abandons it.
        sel = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(mk(3'b011, 32'd6, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1,
                 5'd2, 5'd12, 3'b100, 32'd0, 32'd0, 5'd12));
        for (int i = 0; i < 10; i++) tick();
        check("midreset stalled", 32'(StallE), 32'd1);
        rst = 1'b1;
        tick();
        check("midreset StallE", 32'(StallE), 32'd0);
        check("midreset RegwriteM", 32'(RegwriteM), 32'd0);
        rst = 1'b0;
        addSeven("midreset add");
`else
        sel = 0;
        drive(mk(3'b011, 32'h00010001, 32'h00010001, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1,
                 5'd2, 5'd12, 3'b100, 32'd0, 32'h00010001, 5'd12));
        #1;
        check("nomul StallE", 32'(StallE), 32'd0);
        tick();
        check("nomul ALUoutM", ALUoutM, 32'd0);
        check("nomul ctrlM", 32'({RegwriteM, MemtoregM, MemwriteM}), 32'd4);
        check("nomul WriteRegM", 32'(WriteRegM), 32'd12);
        addSeven("nomul follow add");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
